// File: rtl/tune_seek_ctrl.sv
// Tuning controller: owns the NCO phase increment, applies debounced manual steps
// and runs an autonomous step/settle/measure/decide seek across the band.

module tune_seek_dbnc #(
    parameter int DEB_CYCLES    = 2000000,
    parameter int REPEAT_CYCLES = 25000000,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic CLK,
    input  logic RSTb,
    input  logic btn,
    output logic press
);
    localparam int MAXC = (DEB_CYCLES > REPEAT_CYCLES) ? DEB_CYCLES : REPEAT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [1:0]    sync;
    logic          held;
    logic [CW-1:0] cnt;

    // held marks that the initial press fired; cnt then times the auto-repeat
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            sync  <= '0;
            held  <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            press <= 1'b0;
            if (!sync[1]) begin
                held <= 1'b0;
                cnt  <= '0;
            end else if (!held) begin
                if (cnt == CW'(DEB_CYCLES - 1)) begin
                    press <= 1'b1;
                    held  <= 1'b1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (REPEAT_EN) begin
                if (cnt == CW'(REPEAT_CYCLES - 1)) begin
                    press <= 1'b1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

module tune_seek_ctrl #(
    parameter logic [39:0] INIT_INC      = 40'h2656abde3,
    parameter logic [39:0] FINE_STEP     = 40'h110c6f7,
    parameter logic [39:0] COARSE_STEP   = 40'h1346dc5d,
    parameter logic [39:0] SEEK_STEP     = 40'h5E5F30E,
    parameter logic [39:0] BAND_LO       = 40'h15BFF0457,
    parameter logic [39:0] BAND_HI       = 40'h42b94d940,
    parameter int          DEB_CYCLES    = 2000000,
    parameter int          REPEAT_CYCLES = 25000000,
    parameter int          SETTLE_CYCLES = 1000000,
    parameter int          MEAS_LOG2     = 4,
    parameter logic [15:0] THRESH        = 16'd4000
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic        btn_fine_up,
    input  logic        btn_fine_dn,
    input  logic        btn_coarse_up,
    input  logic        btn_coarse_dn,
    input  logic        btn_seek_up,
    input  logic        btn_seek_dn,
    input  logic [15:0] level,
    input  logic        level_tick,
    output logic [39:0] phase_inc,
    output logic        retune,
    output logic        seeking,
    output logic        found
);
    localparam int NB = 6;
    localparam int NMEAS = 2 ** MEAS_LOG2;
    localparam int NW = MEAS_LOG2 + 1;
    localparam int AW = 16 + MEAS_LOG2;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, STEP, SETTLE, MEASURE, DECIDE} state_t;

    // bit order is priority order: bit 5 wins
    logic [NB-1:0] btn_raw, ev;
    assign btn_raw = {btn_seek_up, btn_seek_dn, btn_coarse_up, btn_coarse_dn,
                      btn_fine_up, btn_fine_dn};

    for (genvar i = 0; i < NB; i++) begin : g_btn
        tune_seek_dbnc #(
            .DEB_CYCLES   (DEB_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .REPEAT_EN    (i < 4)
        ) u_dbnc (
            .CLK  (CLK),
            .RSTb (RSTb),
            .btn  (btn_raw[i]),
            .press(ev[i])
        );
    end

    state_t        state;
    logic          dir_up;
    logic [39:0]   start_inc;
    logic [SW-1:0] settle_cnt;
    logic [AW-1:0] acc;
    logic [NW-1:0] n;

    logic          any_ev, seek_ev, man_ev, man_up;
    logic [39:0]   man_step, man_nxt, seek_nxt;
    logic [40:0]   man_sum, man_dif, seek_sum, seek_dif;
    logic          seek_wrap, seek_hit;
    logic [15:0]   avg;

    always_comb begin
        any_ev   = |ev;
        seek_ev  = ev[5] | ev[4];
        man_ev   = |ev[3:0];
        man_step = (ev[3] | ev[2]) ? COARSE_STEP : FINE_STEP;
        man_up   = ev[3] | (~ev[2] & ev[1]);
        man_sum  = {1'b0, phase_inc} + {1'b0, man_step};
        man_dif  = {1'b0, phase_inc} - {1'b0, man_step};
        if (man_up)
            man_nxt = (man_sum > {1'b0, BAND_HI}) ? BAND_HI : man_sum[39:0];
        else
            man_nxt = (man_dif[40] || man_dif[39:0] < BAND_LO) ? BAND_LO : man_dif[39:0];

        seek_sum = {1'b0, phase_inc} + {1'b0, SEEK_STEP};
        seek_dif = {1'b0, phase_inc} - {1'b0, SEEK_STEP};
        // full-band detection: the step from phase_inc lands on or passes start_inc
        if (dir_up) begin
            seek_wrap = seek_sum > {1'b0, BAND_HI};
            seek_nxt  = seek_wrap ? BAND_LO : seek_sum[39:0];
            seek_hit  = seek_wrap ? ((start_inc > phase_inc) || (start_inc == BAND_LO))
                                  : ((start_inc > phase_inc) && ({1'b0, start_inc} <= seek_sum));
        end else begin
            seek_wrap = seek_dif[40] || (seek_dif[39:0] < BAND_LO);
            seek_nxt  = seek_wrap ? BAND_HI : seek_dif[39:0];
            seek_hit  = seek_wrap ? ((start_inc < phase_inc) || (start_inc == BAND_HI))
                                  : ((start_inc < phase_inc) && (start_inc >= seek_dif[39:0]));
        end
        avg = acc[MEAS_LOG2 +: 16];
    end

    assign seeking = (state != IDLE);

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state      <= IDLE;
            phase_inc  <= INIT_INC;
            retune     <= 1'b0;
            found      <= 1'b0;
            dir_up     <= 1'b0;
            start_inc  <= '0;
            settle_cnt <= '0;
            acc        <= '0;
            n          <= '0;
        end else begin
            retune <= 1'b0;
            if (state != IDLE && any_ev) begin
                // any press aborts a seek and is consumed
                state <= IDLE;
                found <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (seek_ev) begin
                            dir_up    <= ev[5];
                            start_inc <= phase_inc;
                            found     <= 1'b0;
                            state     <= STEP;
                        end else if (man_ev) begin
                            found <= 1'b0;
                            if (man_nxt != phase_inc) begin
                                phase_inc <= man_nxt;
                                retune    <= 1'b1;
                            end
                        end
                    end
                    STEP: begin
                        phase_inc  <= seek_nxt;
                        retune     <= 1'b1;
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end
                    SETTLE: begin
                        if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                            acc   <= '0;
                            n     <= '0;
                            state <= MEASURE;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    MEASURE: begin
                        if (level_tick) begin
                            acc <= acc + {{MEAS_LOG2{1'b0}}, level};
                            n   <= n + 1'b1;
                            if (n == NW'(NMEAS - 1))
                                state <= DECIDE;
                        end
                    end
                    DECIDE: begin
                        if (avg >= THRESH) begin
                            found <= 1'b1;
                            state <= IDLE;
                        end else if (seek_hit) begin
                            state <= IDLE;
                        end else begin
                            state <= STEP;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
